// File: rtl/register_pipe.sv
// register_pipe: DEPTH-stage, WIDTH-bit elastic pipeline register with valid/ready on both sides.
// Latency DEPTH-1 cycles after the accept edge through an empty pipe; one item per cycle sustained.
// Bubbles collapse so empty stages still fill while the output stalls; flush clears all valid bits.
// Optional: define REGISTER_PIPE_STALL_CNT_EN to add a saturating 16-bit output-stall counter port.
module register_pipe #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef REGISTER_PIPE_STALL_CNT_EN
  ,
  output logic [15:0]                  stall_cnt
`endif
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [DEPTH-1:0] adv;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             in_xfer;
  logic             out_xfer;

  // Per-stage advance and next-state. A stage advances unless it and every
  // stage downstream of it are full while the output is stalled; written in
  // that closed form so there is no combinational chain through adv itself.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic             src_v;
    logic [WIDTH-1:0] src_dat;

    if (gi == 0) begin : g_head
      assign src_v   = in_valid;
      assign src_dat = in_data;
    end else begin : g_body
      assign src_v   = v_q[gi-1];
      assign src_dat = data_q[gi-1];
    end

    assign adv[gi]    = out_ready | ~(&v_q[DEPTH-1:gi]);
    assign v_d[gi]    = flush ? 1'b0 : (adv[gi] ? src_v : v_q[gi]);
    // Data is left alone on flush; with its valid bit cleared it is don't-care.
    assign data_d[gi] = (adv[gi] & ~flush) ? src_dat : data_q[gi];
  end

  assign in_ready  = adv[0] & ~flush;
  assign out_valid = v_q[DEPTH-1] & ~flush;
  assign out_data  = data_q[DEPTH-1];
  assign count     = count_q;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;
  assign count_d  = flush ? '0 : (count_q + CW'(in_xfer) - CW'(out_xfer));

  // Stage registers and occupancy; everything is lost immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q     <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= RESET_VAL;
      end
    end else begin
      v_q     <= v_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

`ifdef REGISTER_PIPE_STALL_CNT_EN
  logic [15:0] stall_q;
  logic [15:0] stall_d;

  // Count cycles where the output is offered but refused, saturating at all-ones.
  always_comb begin
    stall_d = stall_q;
    if (flush) begin
      stall_d = '0;
    end else if (out_valid && !out_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: doc/register_pipe.md
Name: register_pipe

Overview:
- Parametrised, elastic successor to the generic D register: a DEPTH-stage, WIDTH-bit pipeline register with a valid/ready handshake on both sides.
- Bubbles collapse, so any empty stage accepts data even while the output is stalled.
- Used between datapath blocks that need registered timing plus back-pressure.
- Provides a synchronous flush and an occupancy count.

Parameters:
- WIDTH, 8, data width in bits (>=1)
- DEPTH, 4, number of register stages (>=1)
- RESET_VAL, {WIDTH{1'b0}}, value loaded into every data stage on reset

Ports:
- clk  input  1  clock; all state updates on posedge
- rst  input  1  asynchronous reset, active-high
- in_valid  input  1  upstream has data on in_data
- in_ready  output  1  pipe can accept in_data this cycle
- in_data  input  WIDTH  write data
- out_valid  output  1  stage DEPTH-1 holds valid data
- out_ready  input  1  downstream accepts out_data this cycle
- out_data  output  WIDTH  contents of stage DEPTH-1
- flush  input  1  synchronous clear of all valid bits
- count  output  $clog2(DEPTH+1)  number of valid stages

Behaviour:
- Interface: one clock (clk); rst is asynchronous and active-high.
- Reset (rst=1, async):
  - all stage valid bits = 0
  - all data stages = RESET_VAL
  - out_valid=0, out_data=RESET_VAL, count=0, in_ready=1 after release
- State: per stage i (0..DEPTH-1), data[i] and v[i]. Stage 0 is the input side; stage DEPTH-1 drives out_data/out_valid combinationally from its registers.
- Advance rule, evaluated combinationally each cycle:
  - adv[DEPTH-1] = !v[DEPTH-1] | out_ready
  - adv[i] = !v[i] | adv[i+1]
  - in_ready = adv[0] & !flush
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
- Stage update at posedge when !flush:
  - Stage i>0 with adv[i]=1 takes data[i-1] and v[i-1].
  - Stage 0 with adv[0]=1 takes in_data and in_valid.
  - A stage with adv=0 holds.
  - Data registers may load with their valid bit low; the held value is don't-care.
- Latency:
  - Item accepted at edge E is on out_data with out_valid=1 after edge E+DEPTH-1 when the downstream stages are empty.
  - DEPTH=1 gives a visible output right after the accept edge.
- Throughput: one item per cycle sustained when out_ready=1.
- Order: strict FIFO; no item is dropped or duplicated.
- Full pipe (all v=1) with out_ready=0:
  - in_ready=0, and all stages hold.
  - Full with out_ready=1: accept and emit in the same cycle; count unchanged.
- Empty pipe: out_valid=0; out_ready is ignored.
- Flush:
  - flush=1 forces out_valid=0 and in_ready=0 combinationally, so no transfer occurs that cycle.
  - At the edge, all v clear and count becomes 0; data registers are not required to change.
  - Flush has priority over all transfers.
- count:
  - Registered.
  - count_next = count + in_xfer - out_xfer, or 0 on flush.
  - Always equals the popcount of v; never exceeds DEPTH.
- Handshake rules:
  - in_data is sampled only on an input transfer.
  - out_data is stable while out_valid=1 and out_ready=0.
  - in_ready does not depend on in_valid.
- Reset mid-operation: all contents are lost immediately (async), and there are no output pulses on release.

Optional Feature:
- Macro: REGISTER_PIPE_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt [15:0]: the number of cycles with out_valid=1 & out_ready=0.
  - Saturates at 16'hFFFF.
  - Cleared by rst (async) and by flush (sync).
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset sequence: rst=1 mid-stream with 3 items loaded -> out_valid=0, count=0, out_data=8'h00 immediately; in_ready=1 after release.
- Latency, DEPTH=4, empty pipe, out_ready=1: push 8'hA5 at edge 0 -> out_valid=1 with out_data=8'hA5 after edge 3, gone after edge 4.
- Back-pressure: out_ready=0, push 8'h01..8'h06 every cycle -> in_ready falls after 4 accepts, count=4; raising out_ready drains 01,02,03,04 in order; then 05 and 06 are accepted and emitted, with no loss.
- Full streaming: full pipe, in_valid=1, out_ready=1 for 10 cycles with incrementing data -> one output per cycle, count stays 4, order preserved.
- Flush: 3 items loaded, flush=1 for one cycle while in_valid=1 -> no accept that cycle, count=0 after the edge, out_valid=0; a subsequent push of 8'h3C emerges alone.
- Stall counter (macro defined): hold out_valid=1 with out_ready=0 for 7 cycles -> stall_cnt=7; flush -> 0. Force 70000 stall cycles -> stall_cnt=16'hFFFF.
